// File: rtl/packet_detect_controller_pkg.sv
// ---------------------------------------------------------------------------
// packet_detect_controller_pkg
//
// Shared definitions for the packet detection controller and its threshold
// comparator: datapath widths, the ratio denominator shift, counter width and
// the FSM state encoding (also exported on StateOut for debug).
// ---------------------------------------------------------------------------
package packet_detect_controller_pkg;

    // Width of the windowed energy and autocorrelation magnitude samples.
    localparam int DATA_W       = 21;
    // Threshold ratio denominator is 2**THRESH_SHIFT (= 8).
    localparam int THRESH_SHIFT = 3;
    // Product width: DATA_W + THRESH_SHIFT, wide enough for either product.
    localparam int PROD_W       = DATA_W + THRESH_SHIFT;
    // Sample, search and holdoff counters.
    localparam int CNT_W        = 16;
    // Consecutive-hit counter (CONFIRM_LEN is limited to 1..255).
    localparam int HIT_W        = 8;
    localparam int STATE_W      = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_SEARCH  = 3'd1,
        ST_CONFIRM = 3'd2,
        ST_FOUND   = 3'd3,
        ST_HOLDOFF = 3'd4
    } stateT;

endpackage

// File: rtl/packet_threshold_compare.sv
// ---------------------------------------------------------------------------
// packet_threshold_compare
//
// Registered hit decision for one correlation sample:
//   hit = InputEnable & (CorrIn*8 >= EnergyIn*THRESH_NUM) & (EnergyIn >= ENERGY_FLOOR)
// Both products are formed at full 24-bit width so nothing is truncated.
// ValidReg is InputEnable delayed by the same register stage, so the
// controller sees (ValidReg, HitReg) as one time-aligned pair.
//
// Ports:
//   Clk, Rst_n   clock, asynchronous active-low reset
//   InputEnable  sample valid for EnergyIn/CorrIn (no backpressure)
//   EnergyIn     windowed energy, unsigned
//   CorrIn       autocorrelation magnitude, unsigned, same scale
//   HitReg       registered hit for the previous cycle's sample
//   ValidReg     registered InputEnable for the previous cycle's sample
// ---------------------------------------------------------------------------
module packet_threshold_compare
    import packet_detect_controller_pkg::*;
#(
    parameter int THRESH_NUM   = 6,
    parameter int ENERGY_FLOOR = 64
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              InputEnable,
    input  logic [DATA_W-1:0] EnergyIn,
    input  logic [DATA_W-1:0] CorrIn,
    output logic              HitReg,
    output logic              ValidReg
);

    logic [PROD_W-1:0] corrScaled;
    logic [PROD_W-1:0] energyScaled;
    logic              ratioOk;
    logic              floorOk;
    logic              hitNext;

    assign corrScaled   = PROD_W'(CorrIn) << THRESH_SHIFT;
    assign energyScaled = PROD_W'(EnergyIn) * PROD_W'(THRESH_NUM);
    assign ratioOk      = (corrScaled >= energyScaled);
    assign floorOk      = (EnergyIn >= DATA_W'(ENERGY_FLOOR));
    assign hitNext      = InputEnable & ratioOk & floorOk;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            HitReg   <= 1'b0;
            ValidReg <= 1'b0;
        end else begin
            HitReg   <= hitNext;
            ValidReg <= InputEnable;
        end
    end

endmodule

// File: rtl/packet_detect_controller.sv
// ---------------------------------------------------------------------------
// packet_detect_controller
//
// Threshold/confirm/holdoff sequencer for the receive correlation chain.
// While Arm is high it searches for CONFIRM_LEN consecutive hits, emits a
// one-cycle PacketFound strobe with the index of the first hit, ignores the
// next HOLDOFF_LEN enabled samples and resumes searching. If MAX_SEARCH
// enabled samples pass in SEARCH without a hit run it strobes Timeout and
// returns to IDLE. Dropping Arm aborts everything at the next clock.
//
// Ports:
//   Clk, Rst_n   clock, asynchronous active-low reset
//   Arm          level: 1 = detection active, 0 = return to IDLE
//   InputEnable  sample valid for EnergyIn/CorrIn (no backpressure)
//   EnergyIn     windowed energy, unsigned
//   CorrIn       autocorrelation magnitude, unsigned
//   PacketFound  one-cycle detection strobe
//   FoundIndex   sample index of the first hit, held until next detection
//   Timeout      one-cycle strobe when the search budget is exhausted
//   Busy         high in any state other than IDLE
//   StateOut     current state code (debug)
// ---------------------------------------------------------------------------
module packet_detect_controller
    import packet_detect_controller_pkg::*;
#(
    parameter int THRESH_NUM   = 6,
    parameter int ENERGY_FLOOR = 64,
    parameter int CONFIRM_LEN  = 16,
    parameter int HOLDOFF_LEN  = 320,
    parameter int MAX_SEARCH   = 65535
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Arm,
    input  logic               InputEnable,
    input  logic [DATA_W-1:0]  EnergyIn,
    input  logic [DATA_W-1:0]  CorrIn,
    output logic               PacketFound,
    output logic [CNT_W-1:0]   FoundIndex,
    output logic               Timeout,
    output logic               Busy,
    output logic [STATE_W-1:0] StateOut
);

    localparam logic [HIT_W-1:0] HIT_TARGET  = HIT_W'(CONFIRM_LEN);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLDOFF_LEN - 1);
    localparam logic [CNT_W-1:0] SEARCH_LAST = CNT_W'(MAX_SEARCH - 1);

    logic             hitReg;
    logic             validReg;
    stateT            state;
    logic [CNT_W-1:0] sampleCnt;
    logic [CNT_W-1:0] searchCnt;
    logic [CNT_W-1:0] holdCnt;
    logic [HIT_W-1:0] hitCnt;
    // Index of the sample that opened the current hit run.
    logic [CNT_W-1:0] candIdx;

    packet_threshold_compare #(
        .THRESH_NUM   (THRESH_NUM),
        .ENERGY_FLOOR (ENERGY_FLOOR)
    ) uCompare (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .InputEnable (InputEnable),
        .EnergyIn    (EnergyIn),
        .CorrIn      (CorrIn),
        .HitReg      (hitReg),
        .ValidReg    (validReg)
    );

    // All decisions use the registered (validReg, hitReg) pair. sampleCnt
    // advances on validReg, so while a sample's hit is being evaluated
    // sampleCnt still equals that sample's index.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= ST_IDLE;
            sampleCnt   <= '0;
            searchCnt   <= '0;
            holdCnt     <= '0;
            hitCnt      <= '0;
            candIdx     <= '0;
            PacketFound <= 1'b0;
            FoundIndex  <= '0;
            Timeout     <= 1'b0;
        end else begin
            PacketFound <= 1'b0;
            Timeout     <= 1'b0;
            if (!Arm) begin
                // Abort: FoundIndex is deliberately kept.
                state     <= ST_IDLE;
                sampleCnt <= '0;
                searchCnt <= '0;
                holdCnt   <= '0;
                hitCnt    <= '0;
                candIdx   <= '0;
            end else begin
                if (state != ST_IDLE && validReg && sampleCnt != '1) begin
                    sampleCnt <= sampleCnt + 1'b1;
                end
                case (state)
                    ST_IDLE: begin
                        state     <= ST_SEARCH;
                        sampleCnt <= '0;
                        searchCnt <= '0;
                        holdCnt   <= '0;
                        hitCnt    <= '0;
                    end
                    ST_SEARCH: begin
                        if (Timeout) begin
                            // Timeout strobe cycle: leave for IDLE next.
                            state     <= ST_IDLE;
                            searchCnt <= '0;
                        end else if (validReg && hitReg) begin
                            // A hit on the budget-exhausting sample wins.
                            state   <= ST_CONFIRM;
                            hitCnt  <= HIT_W'(1);
                            candIdx <= sampleCnt;
                            if (searchCnt == SEARCH_LAST) begin
                                searchCnt <= '0;
                            end
                        end else if (validReg) begin
                            if (searchCnt == SEARCH_LAST) begin
                                Timeout <= 1'b1;
                            end else begin
                                searchCnt <= searchCnt + 1'b1;
                            end
                        end
                    end
                    ST_CONFIRM: begin
                        if (hitCnt >= HIT_TARGET) begin
                            // Only reachable with CONFIRM_LEN = 1.
                            state       <= ST_FOUND;
                            PacketFound <= 1'b1;
                            FoundIndex  <= candIdx;
                            hitCnt      <= '0;
                        end else if (validReg) begin
                            if (hitReg) begin
                                if (hitCnt + 1'b1 == HIT_TARGET) begin
                                    state       <= ST_FOUND;
                                    PacketFound <= 1'b1;
                                    FoundIndex  <= candIdx;
                                    hitCnt      <= '0;
                                end else begin
                                    hitCnt <= hitCnt + 1'b1;
                                end
                            end else begin
                                // Run broken; the search budget keeps running.
                                state  <= ST_SEARCH;
                                hitCnt <= '0;
                            end
                        end
                    end
                    ST_FOUND: begin
                        state   <= ST_HOLDOFF;
                        holdCnt <= '0;
                    end
                    ST_HOLDOFF: begin
                        if (validReg) begin
                            if (holdCnt == HOLD_LAST) begin
                                state     <= ST_SEARCH;
                                holdCnt   <= '0;
                                searchCnt <= '0;
                            end else begin
                                holdCnt <= holdCnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign Busy     = (state != ST_IDLE);
    assign StateOut = state;

endmodule
